// File: rtl/proc_host_driver.sv
// Host-side sequencer for one serial-operand Processor: request in, operands A/B out, result+latency back.
// Optional WAIT watchdog enabled by defining PROC_TIMEOUT_EN (uses parameter TIMEOUT).
module proc_host_driver #(
    parameter int width   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [width-1:0] req_a,
    input  logic [width-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [width-1:0] rsp_result,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             rsp_error,
    output logic [width-1:0] proc_data,
    output logic             proc_preset,
    input  logic [width-1:0] proc_result,
    input  logic             proc_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [width-1:0] op_b;
    logic [CNT_W-1:0] wait_cnt;

`ifdef PROC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_FULL = CNT_W'(TIMEOUT);
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req_ready = (state == S_IDLE);

    // proc_done is sampled here on the rising edge; the Processor moves on falling edges
    always_ff @(posedge clk) begin
        if (preset) begin
            state       <= S_IDLE;
            proc_preset <= 1'b1;
            proc_data   <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_cycles  <= '0;
`ifdef PROC_TIMEOUT_EN
            rsp_error   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    proc_preset <= 1'b1;
                    if (req_valid) begin
                        op_b        <= req_b;
                        proc_data   <= req_a;
                        proc_preset <= 1'b0;
                        state       <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    proc_data <= op_b;
                    state     <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (proc_done) begin
                        rsp_result  <= proc_result;
                        rsp_cycles  <= wait_cnt;
                        rsp_valid   <= 1'b1;
                        proc_preset <= 1'b1;
`ifdef PROC_TIMEOUT_EN
                        rsp_error   <= 1'b0;
`endif
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
`ifdef PROC_TIMEOUT_EN
                        if (wait_cnt == TO_LAST) begin
                            rsp_result  <= '0;
                            rsp_cycles  <= TO_FULL;
                            rsp_valid   <= 1'b1;
                            rsp_error   <= 1'b1;
                            proc_preset <= 1'b1;
                            state       <= S_RESP;
                        end
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef PROC_TIMEOUT_EN
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_proc_host_driver.sv
// Directed bench for proc_host_driver with a behavioural Processor model (result = A+B after N cycles).
module tb_proc_host_driver;

    logic        clk;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [15:0] rsp_cycles;
    logic        rsp_error;
    logic [15:0] proc_data;
    logic        proc_preset;
    logic [15:0] proc_result;
    logic        proc_done;

    proc_host_driver #(.width(16), .CNT_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cycles(rsp_cycles), .rsp_error(rsp_error),
        .proc_data(proc_data), .proc_preset(proc_preset),
        .proc_result(proc_result), .proc_done(proc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor model: falling-edge datapath, A on 1st edge, B on 2nd, done N WAIT cycles later
    int          m_n;
    bit          m_hang;
    int          m_cnt;
    logic [15:0] m_a, m_b;

    always @(negedge clk) begin
        if (proc_preset !== 1'b0) begin
            m_cnt       <= 0;
            proc_done   <= 1'b0;
            proc_result <= '0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 0) m_a <= proc_data;
            if (m_cnt == 1) m_b <= proc_data;
            if (!m_hang && (m_cnt + 1 >= m_n + 3)) begin
                proc_done   <= 1'b1;
                proc_result <= m_a + m_b;
            end
        end
    end

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int lat_in, output int lat_out);
        int l;
        l = lat_in;
        while (!rsp_valid && l < 400) begin
            tick();
            l++;
        end
        if (!rsp_valid) chk("rsp_wait_bound", 64'(rsp_valid), 64'(1));
        lat_out = l;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          n;
        bit          hang;
        logic [15:0] res;
        logic [15:0] cyc;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vq[$];

    task automatic run_txn(input vec_t v);
        int lat;
        m_n       = v.n;
        m_hang    = v.hang;
        rsp_ready = 1'b1;
        chk("txn_req_ready", 64'(req_ready), 64'(1));
        req_a     = v.a;
        req_b     = v.b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("txn_load_a_preset", 64'(proc_preset), 64'(0));
        chk("txn_load_a_data", 64'(proc_data), 64'(v.a));
        tick();
        chk("txn_load_b_data", 64'(proc_data), 64'(v.b));
        wait_rsp(1, lat);
        chk("txn_latency", 64'(lat), 64'(v.lat));
        chk("txn_result", 64'(rsp_result), 64'(v.res));
        chk("txn_cycles", 64'(rsp_cycles), 64'(v.cyc));
        chk("txn_error", 64'(rsp_error), 64'(v.err));
        chk("txn_resp_preset", 64'(proc_preset), 64'(1));
        tick();
        chk("txn_rsp_drop", 64'(rsp_valid), 64'(0));
        chk("txn_back_idle", 64'(req_ready), 64'(1));
    endtask

    initial begin
        int          lat;
        int          n_acc, n_rsp, gap, seen;
        bit          pend;
        logic [15:0] got [2];

        n_pass    = 0;
        n_total   = 0;
        preset    = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        m_n       = 5;
        m_hang    = 1'b0;

        vq.push_back('{a: 16'd12,    b: 16'd30,    n: 5, hang: 1'b0, res: 16'd42,    cyc: 16'd5, err: 1'b0, lat: 8});
        vq.push_back('{a: 16'd0,     b: 16'd0,     n: 0, hang: 1'b0, res: 16'd0,     cyc: 16'd0, err: 1'b0, lat: 3});
        vq.push_back('{a: 16'hFFFF,  b: 16'd1,     n: 2, hang: 1'b0, res: 16'd0,     cyc: 16'd2, err: 1'b0, lat: 5});
`ifdef PROC_TIMEOUT_EN
        vq.push_back('{a: 16'd5,     b: 16'd5,     n: 0, hang: 1'b1, res: 16'd0,     cyc: 16'd8, err: 1'b1, lat: 10});
`endif
        vq.push_back('{a: 16'd100,   b: 16'd200,   n: 1, hang: 1'b0, res: 16'd300,   cyc: 16'd1, err: 1'b0, lat: 4});
        vq.push_back('{a: 16'h7FFF,  b: 16'h7FFF,  n: 3, hang: 1'b0, res: 16'hFFFE,  cyc: 16'd3, err: 1'b0, lat: 6});

        // Reset
        tick();
        tick();
        preset = 1'b0;
        chk("rst_proc_preset", 64'(proc_preset), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_proc_data", 64'(proc_data), 64'(0));
        chk("rst_rsp_result", 64'(rsp_result), 64'(0));
        chk("rst_rsp_cycles", 64'(rsp_cycles), 64'(0));
        chk("rst_rsp_error", 64'(rsp_error), 64'(0));

        foreach (vq[i]) run_txn(vq[i]);

        // Backpressure: response held for 4 cycles, a queued request waits for IDLE
        m_n = 5; m_hang = 1'b0; rsp_ready = 1'b0;
        req_a = 16'd12; req_b = 16'd30; req_valid = 1'b1;
        tick();
        req_a = 16'd2; req_b = 16'd2;
        wait_rsp(0, lat);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid_held", 64'(rsp_valid), 64'(1));
            chk("bp_result_held", 64'(rsp_result), 64'(42));
            chk("bp_req_blocked", 64'(req_ready), 64'(0));
            tick();
        end
        chk("bp_valid_5th", 64'(rsp_valid), 64'(1));
        chk("bp_cycles_held", 64'(rsp_cycles), 64'(5));
        m_n = 1;
        rsp_ready = 1'b1;
        tick();
        chk("bp_released", 64'(rsp_valid), 64'(0));
        chk("bp_idle_ready", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        chk("bp_next_load_a", 64'(proc_data), 64'(2));
        chk("bp_next_preset", 64'(proc_preset), 64'(0));
        wait_rsp(0, lat);
        chk("bp_next_result", 64'(rsp_result), 64'(4));
        chk("bp_next_cycles", 64'(rsp_cycles), 64'(1));
        tick();

        // Mid-operation reset in WAIT, then a fresh request
        m_n = 10; rsp_ready = 1'b1;
        req_a = 16'd9; req_b = 16'd9; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick(); tick();
        preset = 1'b1;
        tick();
        preset = 1'b0;
        chk("mrst_proc_preset", 64'(proc_preset), 64'(1));
        chk("mrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mrst_req_ready", 64'(req_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("mrst_no_response", 64'(seen), 64'(0));
        run_txn('{a: 16'd1, b: 16'd2, n: 2, hang: 1'b0, res: 16'd3, cyc: 16'd2, err: 1'b0, lat: 5});

        // Back-to-back queued requests
        m_n = 1; rsp_ready = 1'b1;
        req_a = 16'd3; req_b = 16'd4; req_valid = 1'b1;
        pend = 1'b1; n_acc = 1; n_rsp = 0; gap = 0;
        got[0] = '0; got[1] = '0;
        for (int cyc = 0; cyc < 200 && n_rsp < 2; cyc++) begin
            tick();
            if (pend) begin
                pend = 1'b0;
                if (n_acc == 1) begin
                    req_a = 16'd5; req_b = 16'd6;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                got[n_rsp] = rsp_result;
                n_rsp++;
            end
            if (n_rsp == 1 && n_acc == 1 && proc_preset) gap++;
            if (req_valid && req_ready) begin
                pend = 1'b1;
                n_acc++;
            end
        end
        chk("b2b_count", 64'(n_rsp), 64'(2));
        chk("b2b_first", 64'(got[0]), 64'(7));
        chk("b2b_second", 64'(got[1]), 64'(11));
        chk("b2b_preset_gap", 64'(gap >= 1), 64'(1));
        tick();
        chk("b2b_idle", 64'(req_ready), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
